// File: rtl/sdf_bf_sequencer.sv
// Control sequencer for one radix-2 single-path delay-feedback FFT stage.
// Optional SDF_SEQ_BYPASS_EN adds a bypass input that turns the stage into a pure M-sample delay.
`timescale 1ns/1ps
module sdf_bf_sequencer #(
   parameter int N = 64,
   parameter int M = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 di_en,
`ifdef SDF_SEQ_BYPASS_EN
   input  logic                 bypass,
`endif
   output logic                 bf_sel,
   output logic                 db_wr_en,
   output logic [$clog2(M)-1:0] db_addr,
   output logic                 tw_en,
   output logic [$clog2(N)-1:0] tw_addr,
   output logic                 do_en,
   output logic                 busy,
   output logic                 frame_done
);
   localparam int NW = $clog2(N);
   localparam int MW = $clog2(M);
   localparam int SH = NW - MW - 1;
   localparam logic [NW-1:0] CNT_LAST = NW'(N - 1);
   localparam logic [NW-1:0] CNT_FD   = NW'(M - 1);
   localparam logic [MW-1:0] POS_LAST = MW'(M - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t          state_reg, state_next;
   logic [NW-1:0]   cnt_reg, cnt_next;
   logic            wrap_reg, wrap_next;
   logic            byp_reg, byp_next;
   logic            byp_in;
   logic            slot, ph, no_y1;
   logic [MW-1:0]   pos;
   logic            bf_next, wr_next, tw_next, do_next, fd_next;
   logic [MW-1:0]   addr_next;
   logic [NW-1:0]   twa_next;

`ifdef SDF_SEQ_BYPASS_EN
   assign byp_in = bypass;
`else
   assign byp_in = 1'b0;
`endif

   assign ph    = cnt_reg[MW];
   assign pos   = cnt_reg[MW-1:0];
   assign slot  = di_en || (state_reg == FLUSH);
   // Until the first butterfly half of a fresh frame, the buffer holds no y1 data.
   assign no_y1 = (state_reg == IDLE) || (state_reg == FILL);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         wrap_reg  <= 1'b0;
         byp_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         wrap_reg  <= wrap_next;
         byp_reg   <= byp_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = slot ? cnt_reg + 1'b1 : cnt_reg;
      wrap_next  = 1'b0;
      byp_next   = byp_reg;
      case (state_reg)
         IDLE: begin
            if (di_en) begin
               state_next = FILL;
               byp_next   = byp_in;
            end
         end
         FILL: begin
            if (di_en && (pos == POS_LAST))
               state_next = RUN;
         end
         RUN: begin
            if (di_en)
               wrap_next = (cnt_reg == CNT_LAST);
            else if (wrap_reg)
               state_next = FLUSH;
         end
         FLUSH: begin
            // A new sample during flush starts the next frame in the same slot.
            if (di_en)
               state_next = RUN;
            else if (pos == POS_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      wr_next   = slot;
      addr_next = slot ? pos : '0;
      bf_next   = slot && ph && !byp_reg;
      do_next   = slot && (ph || !no_y1);
      tw_next   = slot && !ph && !no_y1 && !byp_reg;
      twa_next  = slot ? (NW'(pos) << SH) : '0;
      fd_next   = slot && !no_y1 && (cnt_reg == CNT_FD);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bf_sel     <= 1'b0;
         db_wr_en   <= 1'b0;
         db_addr    <= '0;
         tw_en      <= 1'b0;
         tw_addr    <= '0;
         do_en      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         bf_sel     <= bf_next;
         db_wr_en   <= wr_next;
         db_addr    <= addr_next;
         tw_en      <= tw_next;
         tw_addr    <= twa_next;
         do_en      <= do_next;
         frame_done <= fd_next;
      end
   end

   // Held high through the cycle showing the final output, so it drops after frame_done.
   assign busy = (state_reg != IDLE) || do_en;

endmodule

// File: tb/tb_sdf_bf_sequencer.sv
// Directed bench for sdf_bf_sequencer: N=16/M=8 and N=16/M=4 instances.
`timescale 1ns/1ps
module tb_sdf_bf_sequencer;
   logic clock = 1'b0;
   logic reset_n, di8, di4, byp;
   logic bf8, wr8, tw8, do8, busy8, fd8;
   logic [2:0] addr8;
   logic [3:0] twa8;
   logic bf4, wr4, tw4, do4, busy4, fd4;
   logic [1:0] addr4;
   logic [3:0] twa4;
   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   sdf_bf_sequencer #(.N(16), .M(8)) u8 (
      .clock(clock), .reset_n(reset_n), .di_en(di8),
`ifdef SDF_SEQ_BYPASS_EN
      .bypass(byp),
`endif
      .bf_sel(bf8), .db_wr_en(wr8), .db_addr(addr8), .tw_en(tw8), .tw_addr(twa8),
      .do_en(do8), .busy(busy8), .frame_done(fd8)
   );

   sdf_bf_sequencer #(.N(16), .M(4)) u4 (
      .clock(clock), .reset_n(reset_n), .di_en(di4),
`ifdef SDF_SEQ_BYPASS_EN
      .bypass(byp),
`endif
      .bf_sel(bf4), .db_wr_en(wr4), .db_addr(addr4), .tw_en(tw4), .tw_addr(twa4),
      .do_en(do4), .busy(busy4), .frame_done(fd4)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step8(input logic d, input logic e_wr, input int e_addr, input logic e_bf,
                        input logic e_do, input logic e_tw, input int e_twa,
                        input logic e_fd, input logic e_busy);
      di8 = d;
      di4 = 1'b0;
      @(posedge clock);
      #1;
      $display("m8 t=%0t di=%b wr=%b addr=%0d bf=%b do=%b tw=%b twa=%0d fd=%b busy=%b",
               $time, d, wr8, addr8, bf8, do8, tw8, twa8, fd8, busy8);
      chk1("m8_wr", wr8, e_wr);
      if (e_wr) chkn("m8_addr", 32'(addr8), 32'(e_addr));
      chk1("m8_bf", bf8, e_bf);
      chk1("m8_do", do8, e_do);
      chk1("m8_tw", tw8, e_tw);
      if (e_tw) chkn("m8_twa", 32'(twa8), 32'(e_twa));
      chk1("m8_fd", fd8, e_fd);
      chk1("m8_busy", busy8, e_busy);
   endtask

   task automatic step4(input logic d, input logic e_wr, input int e_addr, input logic e_bf,
                        input logic e_do, input logic e_tw, input int e_twa, input logic e_fd);
      di4 = d;
      di8 = 1'b0;
      @(posedge clock);
      #1;
      $display("m4 t=%0t di=%b wr=%b addr=%0d bf=%b do=%b tw=%b twa=%0d fd=%b busy=%b",
               $time, d, wr4, addr4, bf4, do4, tw4, twa4, fd4, busy4);
      chk1("m4_wr", wr4, e_wr);
      if (e_wr) chkn("m4_addr", 32'(addr4), 32'(e_addr));
      chk1("m4_bf", bf4, e_bf);
      chk1("m4_do", do4, e_do);
      chk1("m4_tw", tw4, e_tw);
      if (e_tw) chkn("m4_twa", 32'(twa4), 32'(e_twa));
      chk1("m4_fd", fd4, e_fd);
   endtask

   // Fresh frame from IDLE: 8 fill slots without output, then 8 butterfly slots.
   task automatic frame8();
      for (int k = 0; k < 16; k++)
         step8(1'b1, 1'b1, k % 8, (k >= 8), (k >= 8), 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic quiet8(input logic e_busy);
      step8(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, e_busy);
   endtask

   task automatic flush8(input int lo, input int hi, input logic d);
      for (int k = lo; k <= hi; k++)
         step8(d, 1'b1, k, 1'b0, 1'b1, 1'b1, k, (k == 7), 1'b1);
   endtask

   task automatic rst_check8(input string tag);
      chk1({tag, "_bf"}, bf8, 1'b0);
      chk1({tag, "_wr"}, wr8, 1'b0);
      chkn({tag, "_addr"}, 32'(addr8), 32'd0);
      chk1({tag, "_do"}, do8, 1'b0);
      chk1({tag, "_tw"}, tw8, 1'b0);
      chkn({tag, "_twa"}, 32'(twa8), 32'd0);
      chk1({tag, "_fd"}, fd8, 1'b0);
      chk1({tag, "_busy"}, busy8, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      di8 = 1'b0;
      di4 = 1'b0;
      byp = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      rst_check8("rst");
      chk1("rst_m4_do", do4, 1'b0);
      chk1("rst_m4_busy", busy4, 1'b0);
      reset_n = 1'b1;

      // contiguous frame, wrap gap, 8-cycle flush
      frame8();
      quiet8(1'b1);
      flush8(0, 7, 1'b0);
      quiet8(1'b0);

      // di_en toggling 1,0: counters freeze on the idle cycles
      for (int k = 0; k < 16; k++) begin
         step8(1'b1, 1'b1, k % 8, (k >= 8), (k >= 8), 1'b0, 0, 1'b0, 1'b1);
         quiet8(1'b1);
      end
      flush8(0, 7, 1'b0);
      quiet8(1'b0);

      // back-to-back frames: second frame carries out the first frame's y1
      frame8();
      for (int k = 0; k < 8; k++)
         step8(1'b1, 1'b1, k, 1'b0, 1'b1, 1'b1, k, (k == 7), 1'b1);
      for (int k = 8; k < 16; k++)
         step8(1'b1, 1'b1, k - 8, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      quiet8(1'b1);
      flush8(0, 7, 1'b0);
      quiet8(1'b0);

      // new frame pre-empts the flush at slot 3
      frame8();
      quiet8(1'b1);
      flush8(0, 2, 1'b0);
      flush8(3, 7, 1'b1);
      for (int k = 8; k < 16; k++)
         step8(1'b1, 1'b1, k - 8, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
      quiet8(1'b1);
      flush8(0, 7, 1'b0);
      quiet8(1'b0);

      // asynchronous reset mid-frame, then a clean restart at cnt=0
      for (int k = 0; k < 5; k++)
         step8(1'b1, 1'b1, k, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      di8 = 1'b0;
      #2 reset_n = 1'b0;
      #1 rst_check8("midrst");
      @(posedge clock);
      #1 reset_n = 1'b1;
      frame8();
      quiet8(1'b1);
      flush8(0, 7, 1'b0);
      quiet8(1'b0);

      // M=4 instance: twiddle stride 2, address cycles 0..3
      for (int k = 0; k < 16; k++)
         step4(1'b1, 1'b1, k % 4, ((k / 4) % 2 == 1), (k >= 4), ((k / 4) == 2),
               (k % 4) * 2, 1'b0);
      step4(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      for (int k = 0; k < 4; k++)
         step4(1'b0, 1'b1, k, 1'b0, 1'b1, 1'b1, k * 2, (k == 3));
      step4(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      chk1("m4_busy_end", busy4, 1'b0);

`ifdef SDF_SEQ_BYPASS_EN
      // bypass latched at frame start; later toggling is ignored
      for (int k = 0; k < 16; k++) begin
         byp = (k < 4);
         step8(1'b1, 1'b1, k % 8, 1'b0, (k >= 8), 1'b0, 0, 1'b0, 1'b1);
      end
      quiet8(1'b1);
      for (int k = 0; k < 8; k++)
         step8(1'b0, 1'b1, k, 1'b0, 1'b1, 1'b0, 0, (k == 7), 1'b1);
      quiet8(1'b0);
      byp = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
